key_history_fsm: RTL and testbench

- Sits between the keypad row/column scanner and the dual seven-segment driver.
- Takes the scanner's raw "key present" level and 4-bit key code, then debounces both press and release.
- Registers exactly one new key per physical press, shifting it into a two-digit history (the new key becomes the low digit; the previous low digit becomes the high digit).
- The seven-segment driver consumes digit_hi/digit_lo directly.

---
 rtl/keypad_pkg.sv | 20 ++
 rtl/key_history_fsm_debounce_timer.sv | 33 +++
 rtl/key_history_fsm.sv | 117 +++++++++++
 tb/tb_key_history_fsm.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad history path.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    typedef logic [3:0] hex_digit_t;

    localparam int DEBOUNCE_DEFAULT = 2400000;

    // True while a debounced key is considered down (held or releasing).
    function automatic logic is_hold_state(input key_state_t s);
        return (s == HELD) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/key_history_fsm_debounce_timer.sv
// Stability timer shared by the press and release debounce phases.
// done flags the last counted cycle so the FSM can leave on that edge.
module debounce_timer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count stable cycles; clear wins over enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == LAST_CNT);

endmodule

// File: rtl/key_history_fsm.sv
// Debounces the keypad scanner and keeps a two-digit history of accepted
// keys for the seven-segment driver. One key is recorded per physical press.
module key_history_fsm
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo,
    output logic       new_key,
    output logic       key_held
);

    key_state_t state_r;
    key_state_t state_next_s;
    hex_digit_t cand_r;
    logic       timer_clr_s;
    logic       timer_en_s;
    logic       timer_done_s;
    logic       accept_s;

    debounce_timer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_timer (
        .clk  (int_osc),
        .rst_n(reset),
        .clr  (timer_clr_s),
        .en   (timer_en_s),
        .done (timer_done_s)
    );

    // Next-state and timer control; any instability sends the FSM back a step.
    always_comb begin
        state_next_s = state_r;
        timer_clr_s  = 1'b0;
        timer_en_s   = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                timer_clr_s = 1'b1;
                if (key_valid) begin
                    state_next_s = PRESS_WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!key_valid || (key_code != cand_r)) begin
                    state_next_s = IDLE;
                    timer_clr_s  = 1'b1;
                end else if (timer_done_s) begin
                    state_next_s = HELD;
                    timer_clr_s  = 1'b1;
                    accept_s     = 1'b1;
                end else begin
                    timer_en_s = 1'b1;
                end
            end
            HELD: begin
                timer_clr_s = 1'b1;
                if (!key_valid) begin
                    state_next_s = RELEASE_WAIT;
                end else begin
                    state_next_s = HELD;
                end
            end
            RELEASE_WAIT: begin
                if (key_valid) begin
                    state_next_s = HELD;
                    timer_clr_s  = 1'b1;
                end else if (timer_done_s) begin
                    state_next_s = IDLE;
                    timer_clr_s  = 1'b1;
                end else begin
                    timer_en_s = 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
                timer_clr_s  = 1'b1;
            end
        endcase
    end

    // State, candidate capture and registered outputs; digits move only on accept.
    always_ff @(posedge int_osc) begin
        if (!reset) begin
            state_r  <= IDLE;
            cand_r   <= 4'h0;
            digit_hi <= 4'h0;
            digit_lo <= 4'h0;
            new_key  <= 1'b0;
            key_held <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            new_key  <= accept_s;
            key_held <= is_hold_state(state_next_s);
            if ((state_r == IDLE) && key_valid) begin
                cand_r <= key_code;
            end else begin
                cand_r <= cand_r;
            end
            if (accept_s) begin
                digit_hi <= digit_lo;
                digit_lo <= cand_r;
            end else begin
                digit_hi <= digit_hi;
                digit_lo <= digit_lo;
            end
        end
    end

endmodule

// File: tb/tb_key_history_fsm.sv
// Self-checking bench for key_history_fsm with a short debounce window.
module tb_key_history_fsm;

    localparam int D = 4;

    logic       int_osc;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] digit_hi;
    logic [3:0] digit_lo;
    logic       new_key;
    logic       key_held;

    key_history_fsm #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .int_osc  (int_osc),
        .reset    (reset),
        .key_valid(key_valid),
        .key_code (key_code),
        .digit_hi (digit_hi),
        .digit_lo (digit_lo),
        .new_key  (new_key),
        .key_held (key_held)
    );

    initial int_osc = 1'b0;
    always #5 int_osc = ~int_osc;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    // Reference model: run lengths of stable samples, not an FSM encoding.
    int         press_run;
    int         rel_run;
    logic [3:0] press_code;
    logic       m_down;
    logic [3:0] m_hi;
    logic [3:0] m_lo;
    logic       m_new;

    typedef struct {
        logic       rst;
        logic       v;
        logic [3:0] code;
        logic [3:0] hi;
        logic [3:0] lo;
        logic       nk;
        logic       held;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_step(input logic r, input logic v, input logic [3:0] c);
        m_new = 1'b0;
        if (!r) begin
            press_run = 0; rel_run = 0; press_code = 4'h0;
            m_down = 1'b0; m_hi = 4'h0; m_lo = 4'h0;
        end else if (!m_down) begin
            if (press_run == 0) begin
                if (v) begin
                    press_code = c;
                    press_run  = 1;
                end
            end else if (!v || (c != press_code)) begin
                press_run = 0;
            end else begin
                press_run++;
                if (press_run == D + 1) begin
                    m_hi = m_lo; m_lo = press_code; m_new = 1'b1;
                    m_down = 1'b1; rel_run = 0; press_run = 0;
                end
            end
        end else begin
            if (!v) begin
                rel_run++;
                if (rel_run == D + 1) begin
                    m_down = 1'b0; rel_run = 0;
                end
            end else begin
                rel_run = 0;
            end
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic step(input logic r, input logic v, input logic [3:0] c);
        reset = r; key_valid = v; key_code = c;
        @(posedge int_osc);
        model_step(r, v, c);
        #1;
        chk("digit_hi", int'(digit_hi), int'(m_hi));
        chk("digit_lo", int'(digit_lo), int'(m_lo));
        chk("new_key",  int'(new_key),  int'(m_new));
        chk("key_held", int'(key_held), int'(m_down));
        if (new_key) pulses++;
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] c,
                                input logic [3:0] hi, input logic [3:0] lo,
                                input logic nk, input logic held);
        vec_t t;
        t.rst = r; t.v = v; t.code = c; t.hi = hi; t.lo = lo; t.nk = nk; t.held = held;
        return t;
    endfunction

    initial begin
        logic v;
        logic [3:0] c;
        int seg;
        int p0;

        reset = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        press_run = 0; rel_run = 0; press_code = 4'h0;
        m_down = 1'b0; m_hi = 4'h0; m_lo = 4'h0; m_new = 1'b0;

        // Reset with a key down, then a timed clean press, release, second press.
        tbl[0]  = mk(1'b0, 1'b1, 4'h7, 4'h0, 4'h0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 4'h7, 4'h0, 4'h0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 4'h7, 4'h0, 4'h0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 1'b1, 4'h7, 4'h0, 4'h0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b1, 4'h7, 4'h0, 4'h0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 1'b1, 4'h7, 4'h0, 4'h0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 1'b1, 4'h7, 4'h0, 4'h0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, 1'b1, 4'h7, 4'h0, 4'h7, 1'b1, 1'b1);
        tbl[8]  = mk(1'b1, 1'b1, 4'h7, 4'h0, 4'h7, 1'b0, 1'b1);
        tbl[9]  = mk(1'b1, 1'b0, 4'h0, 4'h0, 4'h7, 1'b0, 1'b1);
        tbl[10] = mk(1'b1, 1'b0, 4'h0, 4'h0, 4'h7, 1'b0, 1'b1);
        tbl[11] = mk(1'b1, 1'b0, 4'h0, 4'h0, 4'h7, 1'b0, 1'b1);
        tbl[12] = mk(1'b1, 1'b0, 4'h0, 4'h0, 4'h7, 1'b0, 1'b1);
        tbl[13] = mk(1'b1, 1'b0, 4'h0, 4'h0, 4'h7, 1'b0, 1'b0);
        tbl[14] = mk(1'b1, 1'b1, 4'h5, 4'h0, 4'h7, 1'b0, 1'b0);
        tbl[15] = mk(1'b1, 1'b1, 4'h5, 4'h0, 4'h7, 1'b0, 1'b0);
        tbl[16] = mk(1'b1, 1'b1, 4'h5, 4'h0, 4'h7, 1'b0, 1'b0);
        tbl[17] = mk(1'b1, 1'b1, 4'h5, 4'h0, 4'h7, 1'b0, 1'b0);
        tbl[18] = mk(1'b1, 1'b1, 4'h5, 4'h7, 4'h5, 1'b1, 1'b1);
        tbl[19] = mk(1'b1, 1'b1, 4'h9, 4'h7, 4'h5, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].code);
            chk($sformatf("tbl%0d_hi", i),   int'(digit_hi), int'(tbl[i].hi));
            chk($sformatf("tbl%0d_lo", i),   int'(digit_lo), int'(tbl[i].lo));
            chk($sformatf("tbl%0d_new", i),  int'(new_key),  int'(tbl[i].nk));
            chk($sformatf("tbl%0d_held", i), int'(key_held), int'(tbl[i].held));
        end

        // Held for 100 cycles with a wandering code: no further strobes.
        p0 = pulses;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 4'(i));
        chk("held_no_repeat", pulses - p0, 0);

        // Press 5, 9, 2 from a clean reset.
        step(1'b0, 1'b0, 4'h0);
        p0 = pulses;
        for (int k = 0; k < 3; k++) begin
            c = (k == 0) ? 4'h5 : ((k == 1) ? 4'h9 : 4'h2);
            for (int i = 0; i < 6; i++)  step(1'b1, 1'b1, c);
            for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'h0);
        end
        chk("seq_pulses", pulses - p0, 3);
        chk("seq_hi", int'(digit_hi), 9);
        chk("seq_lo", int'(digit_lo), 2);

        // Press bounce 1,1,0,1,1,1,1,1: single strobe on the last sample.
        p0 = pulses;
        step(1'b1, 1'b1, 4'h3); step(1'b1, 1'b1, 4'h3); step(1'b1, 1'b0, 4'h3);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'h3);
        chk("bounce_early", pulses - p0, 0);
        step(1'b1, 1'b1, 4'h3);
        chk("bounce_strobe", int'(new_key), 1);
        chk("bounce_lo", int'(digit_lo), 3);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'h0);

        // Code change 3 -> 4 mid-debounce restarts with 4.
        p0 = pulses;
        step(1'b1, 1'b1, 4'h3); step(1'b1, 1'b1, 4'h3);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'h4);
        chk("chg_pulses", pulses - p0, 1);
        chk("chg_lo", int'(digit_lo), 4);
        chk("chg_hi", int'(digit_hi), 3);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'h0);

        // Accept 6, then release bounce 0,0,1,0 then steady low.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'h6);
        p0 = pulses;
        step(1'b1, 1'b0, 4'h0); step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'h6); step(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0);
        chk("rel_still_held", int'(key_held), 1);
        step(1'b1, 1'b0, 4'h0);
        chk("rel_idle", int'(key_held), 0);
        chk("rel_no_strobe", pulses - p0, 0);
        chk("rel_lo", int'(digit_lo), 6);

        // Reset mid-debounce discards the press and clears the digits.
        p0 = pulses;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'h8);
        step(1'b0, 1'b1, 4'h8);
        chk("rst_mid_hi", int'(digit_hi), 0);
        chk("rst_mid_lo", int'(digit_lo), 0);
        chk("rst_mid_held", int'(key_held), 0);
        chk("rst_mid_pulses", pulses - p0, 0);
        step(1'b1, 1'b0, 4'h0);

        // Random run-length stimulus against the model.
        seg = 0; v = 1'b0; c = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if (seg == 0) begin
                seg = int'($urandom_range(1, 9));
                v = 1'($urandom_range(0, 1));
                c = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 15) == 0) c = 4'($urandom_range(0, 15));
            seg--;
            step(($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1, v, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
